// File: rtl/core_bus_pkg.sv
// Shared types and helpers for the core-to-Wishbone bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_bus_pkg;

  // Bridge FSM: wait for a request, run one Wishbone cycle, report completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Read data handed back when the slave never acknowledges.
  localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEADBEEF;

  // One byte select per data byte.
  function automatic int sel_width(input int data_width);
    return data_width / 8;
  endfunction

  // Width of a port index, never narrower than one bit.
  function automatic int idx_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Latency: grant is combinational; pointer moves on the edge where update is high.
// Backpressure: none; the caller pulses update only when the grant is consumed.
// Ports: clk/rst_n, req (per-port request), update (advance pointer past winner),
//        grant (one-hot winner), any_req (some port is requesting).
module rr_arbiter
  import core_bus_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 update,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 any_req
);

  localparam int PW = idx_width(NUM_PORTS);

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic          found;
  int            cand;

  // Scan from the pointer, wrapping, and take the first active request.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = (int'(ptr) + i) % NUM_PORTS;
      if (!found && req[cand]) begin
        found        = 1'b1;
        grant[cand]  = 1'b1;
        grant_idx    = PW'(cand);
      end
    end
  end

  assign any_req = |req;

  // Next search starts just after the port that won.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (update) begin
      ptr <= (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/core_wb_bridge.sv
// Bridge from NUM_PORTS core request ports onto one Wishbone classic master, one transaction at a time.
// Latency: request -> cyc/stb next edge -> p_ack the edge after core_ack (+1 with WB_PIPELINED_RESP_EN).
// Backpressure: requests are levels held until p_ack; losers wait in round-robin order; bus timeout aborts.
// Ports: p_* core side (rd_en/wr_en/byte_enable/addr/wdata in, rdata/ack/err out),
//        core_* Wishbone master (cyc/stb/we/sel/addr/data_out out, data_in/ack in).
// Option WB_PIPELINED_RESP_EN: register core_ack/core_data_in before use, single-cycle stb.
module core_wb_bridge
  import core_bus_pkg::*;
#(
  parameter int                    NUM_PORTS      = 2,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = DATA_WIDTH'(DEFAULT_TIMEOUT_DATA),
  localparam int                   SEL_WIDTH      = sel_width(DATA_WIDTH)
) (
  input  logic                            sys_clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            p_rd_en,
  input  logic [NUM_PORTS-1:0]            p_wr_en,
  input  logic [NUM_PORTS*SEL_WIDTH-1:0]  p_byte_enable,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] p_wdata,
  output logic [DATA_WIDTH-1:0]           p_rdata,
  output logic [NUM_PORTS-1:0]            p_ack,
  output logic                            p_err,
  output logic                            core_cyc,
  output logic                            core_stb,
  output logic                            core_we,
  output logic [SEL_WIDTH-1:0]            core_sel,
  output logic [ADDR_WIDTH-1:0]           core_addr,
  output logic [DATA_WIDTH-1:0]           core_data_out,
  input  logic [DATA_WIDTH-1:0]           core_data_in,
  input  logic                            core_ack
);

  localparam int             TW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0]  TMAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TLIMIT = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  state_t                   state, state_nxt;
  logic [NUM_PORTS-1:0]     req, grant, grant_r;
  logic                     any_req, arb_update;
  logic [ADDR_WIDTH-1:0]    addr_mux, addr_r;
  logic [SEL_WIDTH-1:0]     sel_mux, sel_r;
  logic [DATA_WIDTH-1:0]    wdata_mux, wdata_r, rdata_r;
  logic                     we_mux, we_r, err_r;
  logic [TW-1:0]            tcnt;
  logic                     timeout_hit;
  logic                     ack_use;
  logic [DATA_WIDTH-1:0]    data_use;

  // A port asserting both enables is a writer, so either enable is a request.
  assign req        = p_rd_en | p_wr_en;
  assign arb_update = (state == IDLE) && any_req;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk     (sys_clk),
    .rst_n   (rst_n),
    .req     (req),
    .update  (arb_update),
    .grant   (grant),
    .any_req (any_req)
  );

  // Select the winner's request fields for latching.
  always_comb begin
    addr_mux  = '0;
    sel_mux   = '0;
    wdata_mux = '0;
    we_mux    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        addr_mux  = p_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_mux   = p_byte_enable[i*SEL_WIDTH +: SEL_WIDTH];
        wdata_mux = p_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        we_mux    = p_wr_en[i];
      end
    end
  end

  assign core_cyc = (state == BUS);

`ifdef WB_PIPELINED_RESP_EN
  logic                  ack_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  stb_sent;

  // Slave response is registered so the Controller's ack path ends at a flop.
  // An ack seen outside a cycle is masked so it cannot complete the next one.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= 1'b0;
      data_q   <= '0;
      stb_sent <= 1'b0;
    end else begin
      ack_q    <= core_ack & core_cyc;
      data_q   <= core_data_in;
      stb_sent <= (state == BUS);
    end
  end

  assign ack_use  = ack_q;
  assign data_use = data_q;
  assign core_stb = (state == BUS) && !stb_sent;
`else
  assign ack_use  = core_ack;
  assign data_use = core_data_in;
  assign core_stb = (state == BUS);
`endif

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt == TLIMIT);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUS;
      BUS:     if (ack_use || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are frozen at grant; later changes on the port are ignored.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_r <= '0;
      addr_r  <= '0;
      sel_r   <= '0;
      wdata_r <= '0;
      we_r    <= 1'b0;
      rdata_r <= '0;
      err_r   <= 1'b0;
      tcnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (any_req) begin
            grant_r <= grant;
            addr_r  <= addr_mux;
            sel_r   <= sel_mux;
            wdata_r <= wdata_mux;
            we_r    <= we_mux;
            rdata_r <= '0;
            err_r   <= 1'b0;
          end
        end
        BUS: begin
          if (tcnt != TMAX) tcnt <= tcnt + 1'b1;
          if (ack_use) begin
            rdata_r <= we_r ? '0 : data_use;
            err_r   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_r <= we_r ? '0 : TIMEOUT_DATA;
            err_r   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_we       = we_r;
  assign core_sel      = sel_r;
  assign core_addr     = addr_r;
  assign core_data_out = wdata_r;

  assign p_ack   = (state == RESP) ? grant_r : '0;
  assign p_rdata = (state == RESP) ? rdata_r : '0;
  assign p_err   = (state == RESP) && err_r;

endmodule

// File: tb/tb_core_wb_bridge.sv
// Directed bench for core_wb_bridge (2 ports, 32-bit, 16-cycle timeout).
// Works with or without WB_PIPELINED_RESP_EN; latency expectations shift by one cycle.
// Slave model acks slave_wait cycles after cyc rises, or never when disabled.
module tb_core_wb_bridge;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;
`ifdef WB_PIPELINED_RESP_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic              sys_clk = 1'b0;
  logic              rst_n   = 1'b1;
  logic [NP-1:0]     p_rd_en, p_wr_en;
  logic [NP*SW-1:0]  p_byte_enable;
  logic [NP*AW-1:0]  p_addr;
  logic [NP*DW-1:0]  p_wdata;
  logic [DW-1:0]     p_rdata;
  logic [NP-1:0]     p_ack;
  logic              p_err;
  logic              core_cyc, core_stb, core_we;
  logic [SW-1:0]     core_sel;
  logic [AW-1:0]     core_addr;
  logic [DW-1:0]     core_data_out, core_data_in;
  logic              core_ack;

  logic              slave_en, force_ack;
  int                slave_wait;
  logic [DW-1:0]     slave_rdata;
  int                scnt;

  int checks   = 0;
  int failures = 0;

  core_wb_bridge #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .p_rd_en(p_rd_en), .p_wr_en(p_wr_en), .p_byte_enable(p_byte_enable),
    .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(p_rdata), .p_ack(p_ack), .p_err(p_err),
    .core_cyc(core_cyc), .core_stb(core_stb), .core_we(core_we), .core_sel(core_sel),
    .core_addr(core_addr), .core_data_out(core_data_out),
    .core_data_in(core_data_in), .core_ack(core_ack)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)        scnt <= 0;
    else if (!core_cyc) scnt <= 0;
    else               scnt <= scnt + 1;
  end

  assign core_ack     = force_ack | (slave_en & core_cyc & (scnt == slave_wait));
  assign core_data_in = slave_rdata;

  task automatic step;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset;
    p_rd_en = '0; p_wr_en = '0; p_byte_enable = '0; p_addr = '0; p_wdata = '0;
    slave_en = 1'b0; force_ack = 1'b0; slave_wait = 0; slave_rdata = '0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({core_cyc, core_stb, core_we, core_sel, core_addr, core_data_out} !== '0) begin
      failures++;
      $display("FAIL reset_bus: got cyc=%b stb=%b we=%b sel=%h addr=%h dout=%h required all 0",
               core_cyc, core_stb, core_we, core_sel, core_addr, core_data_out);
    end
    checks++;
    if ({p_ack, p_err, p_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_resp: got ack=%b err=%b rdata=%h required all 0", p_ack, p_err, p_rdata);
    end
    step; step;
    @(negedge sys_clk) rst_n = 1'b1;
    step;
  endtask

  task automatic test_read;
    int n = 0;
    slave_en = 1'b1; slave_wait = 1; slave_rdata = 32'h12345678;
    p_addr[31:0] = 32'h100; p_rd_en = 2'b01;
    while (n < 40 && p_ack == '0) begin
      step; n++;
      if (n == 1) begin
        checks++;
        if ({core_cyc, core_stb, core_we} !== 3'b110 || core_addr !== 32'h100) begin
          failures++;
          $display("FAIL read_issue: got cyc/stb/we=%b%b%b addr=%h required 110 addr=00000100",
                   core_cyc, core_stb, core_we, core_addr);
        end
      end
      if (n == 2) begin
        checks++;
        if (core_stb !== (EXTRA == 0)) begin
          failures++;
          $display("FAIL read_stb_width: got stb=%b in second bus cycle required %b", core_stb, EXTRA == 0);
        end
      end
    end
    checks++;
    if (n != 3 + EXTRA) begin
      failures++;
      $display("FAIL read_latency: got %0d cycles required %0d", n, 3 + EXTRA);
    end
    checks++;
    if (p_ack !== 2'b01 || p_rdata !== 32'h12345678 || p_err !== 1'b0) begin
      failures++;
      $display("FAIL read_resp: got ack=%b rdata=%h err=%b required 01 12345678 0", p_ack, p_rdata, p_err);
    end
    p_rd_en = '0;
    step;
    checks++;
    if (p_ack !== 2'b00 || core_cyc !== 1'b0) begin
      failures++;
      $display("FAIL read_pulse: got ack=%b cyc=%b after response required 00 0", p_ack, core_cyc);
    end
  endtask

  task automatic test_write;
    int n = 0;
    slave_en = 1'b1; slave_wait = 2;
    p_addr[63:32] = 32'h2004; p_wdata[63:32] = 32'hA5A5A5A5; p_byte_enable[7:4] = 4'b0011;
    p_wr_en = 2'b10;
    while (n < 40 && p_ack == '0) begin
      step; n++;
      if (core_cyc) begin
        checks++;
        if ({core_we, core_sel, core_addr, core_data_out} !== {1'b1, 4'b0011, 32'h2004, 32'hA5A5A5A5}) begin
          failures++;
          $display("FAIL write_stable: cycle %0d got we=%b sel=%b addr=%h dout=%h required 1 0011 00002004 a5a5a5a5",
                   n, core_we, core_sel, core_addr, core_data_out);
        end
      end
    end
    checks++;
    if (n != 4 + EXTRA || p_ack !== 2'b10 || p_rdata !== '0 || p_err !== 1'b0) begin
      failures++;
      $display("FAIL write_resp: got n=%0d ack=%b rdata=%h err=%b required n=%0d 10 00000000 0",
               n, p_ack, p_rdata, p_err, 4 + EXTRA);
    end
    p_wr_en = '0;
    step;
    // Both enables high with no byte enables: still a write, issued with sel=0.
    n = 0;
    p_addr[63:32] = 32'h2008; p_byte_enable[7:4] = 4'b0000;
    p_rd_en = 2'b10; p_wr_en = 2'b10;
    while (n < 40 && p_ack == '0) begin
      step; n++;
      if (n == 1) begin
        checks++;
        if (core_we !== 1'b1 || core_sel !== 4'b0000 || core_cyc !== 1'b1) begin
          failures++;
          $display("FAIL rdwr_sel0: got cyc=%b we=%b sel=%b required 1 1 0000", core_cyc, core_we, core_sel);
        end
      end
    end
    checks++;
    if (p_ack !== 2'b10) begin
      failures++;
      $display("FAIL rdwr_ack: got ack=%b required 10", p_ack);
    end
    p_rd_en = '0; p_wr_en = '0;
    step;
  endtask

  task automatic test_idle_ack;
    force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++;
      if (p_ack !== 2'b00 || core_cyc !== 1'b0) begin
        failures++;
        $display("FAIL idle_ack: got ack=%b cyc=%b with stray core_ack required 00 0", p_ack, core_cyc);
      end
    end
    force_ack = 1'b0;
  endtask

  task automatic test_back_to_back;
    int cyc_n = 0, last = 0, k = 0, cnt0 = 0, cnt1 = 0;
    logic [NP-1:0] exp_ack;
    slave_en = 1'b1; slave_wait = 0; slave_rdata = 32'h0BADF00D;
    p_addr = {32'h0000_5000, 32'h0000_4000};
    p_rd_en = 2'b11;
    while (k < 20 && cyc_n < 400) begin
      step; cyc_n++;
      if (p_ack != '0) begin
        exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if (p_ack !== exp_ack) begin
          failures++;
          $display("FAIL b2b_grant: txn %0d got ack=%b required %b", k, p_ack, exp_ack);
        end
        if (k > 0) begin
          checks++;
          if (cyc_n - last != 3 + EXTRA) begin
            failures++;
            $display("FAIL b2b_period: txn %0d got spacing %0d required %0d", k, cyc_n - last, 3 + EXTRA);
          end
        end
        if (p_ack[0]) cnt0++;
        if (p_ack[1]) cnt1++;
        last = cyc_n;
        k++;
      end
    end
    checks++;
    if (k != 20 || cnt0 != 10 || cnt1 != 10) begin
      failures++;
      $display("FAIL b2b_fair: got txns=%0d port0=%0d port1=%0d required 20 10 10", k, cnt0, cnt1);
    end
    p_rd_en = '0;
    step; step;
  endtask

  task automatic test_timeout;
    int n = 0, cyc_cnt = 0;
    slave_en = 1'b0;
    p_addr[31:0] = 32'h300; p_rd_en = 2'b01;
    while (n < 100 && p_ack == '0) begin
      step; n++;
      if (core_cyc) cyc_cnt++;
    end
    checks++;
    if (cyc_cnt != TO || core_cyc !== 1'b0) begin
      failures++;
      $display("FAIL timeout_len: got cyc high %0d cycles, cyc now %b required %0d and 0", cyc_cnt, core_cyc, TO);
    end
    checks++;
    if (p_ack !== 2'b01 || p_err !== 1'b1 || p_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL timeout_resp: got ack=%b err=%b rdata=%h required 01 1 deadbeef", p_ack, p_err, p_rdata);
    end
    p_rd_en = '0;
    step;
    checks++;
    if (p_err !== 1'b0 || p_ack !== 2'b00) begin
      failures++;
      $display("FAIL timeout_clear: got err=%b ack=%b required 0 00", p_err, p_ack);
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    slave_en = 1'b0;
    p_addr[63:32] = 32'h400; p_rd_en = 2'b10;
    step; step; step;
    checks++;
    if (core_cyc !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre: got cyc=%b before reset required 1", core_cyc);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({core_cyc, core_stb, p_ack} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset: got cyc=%b stb=%b ack=%b required 0 0 00", core_cyc, core_stb, p_ack);
    end
    p_rd_en = '0;
    step; step;
    @(negedge sys_clk) rst_n = 1'b1;
    step;
    slave_en = 1'b1; slave_wait = 0; slave_rdata = 32'hCAFEF00D;
    p_addr[63:32] = 32'h404; p_rd_en = 2'b10;
    while (n < 40 && p_ack == '0) begin
      step; n++;
    end
    checks++;
    if (n != 2 + EXTRA || p_ack !== 2'b10 || p_rdata !== 32'hCAFEF00D || p_err !== 1'b0) begin
      failures++;
      $display("FAIL mid_recover: got n=%0d ack=%b rdata=%h err=%b required n=%0d 10 cafef00d 0",
               n, p_ack, p_rdata, p_err, 2 + EXTRA);
    end
    p_rd_en = '0;
    step;
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_idle_ack;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
